// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline controller: state encodings, stage-control
// bundle, and the decode from the selected hazard condition to stage controls.
package pipeline_pkg;

  localparam int REG_W                  = 5;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT   = 2'd3;

  localparam int PERF_N     = 2;
  localparam int PERF_STALL = 0;
  localparam int PERF_FLUSH = 1;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic mem_wb_en;
    logic mem_wb_flush;
  } stage_ctrl_t;

  // Reset drives every enable and every flush so the whole pipeline is cleared.
  localparam stage_ctrl_t CTRL_CLEAR = '1;

  function automatic stage_ctrl_t stage_ctrl(input logic [1:0] cond);
    stage_ctrl_t c;
    c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
          id_ex_en: 1'b1, id_ex_flush: 1'b0,
          ex_mem_en: 1'b1, ex_mem_flush: 1'b0,
          mem_wb_en: 1'b1, mem_wb_flush: 1'b0};
    case (cond)
      ST_MEM_WAIT: begin
        // Everything up to MEM holds; WB receives a bubble.
        c.pc_en        = 1'b0;
        c.if_id_en     = 1'b0;
        c.id_ex_en     = 1'b0;
        c.ex_mem_en    = 1'b0;
        c.mem_wb_flush = 1'b1;
      end
      ST_REDIRECT: begin
        c.if_id_flush = 1'b1;
        c.id_ex_flush = 1'b1;
      end
      ST_LOAD_STALL: begin
        // Hold PC and IF/ID, inject a bubble into EX behind the load.
        c.pc_en       = 1'b0;
        c.if_id_en    = 1'b0;
        c.id_ex_flush = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and the load in EX.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_wb_load,
  input  logic [REG_W-1:0] ex_wb_rd,
  output logic             load_use
);

  logic [REG_W-1:0] src [2];
  logic [1:0]       uses;
  logic [1:0]       match;

  assign src[0]  = id_rs1;
  assign src[1]  = id_rs2;
  assign uses[0] = id_uses_rs1;
  assign uses[1] = id_uses_rs2;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_src
    assign match[gi] = uses[gi] & (src[gi] == ex_wb_rd);
  end

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_wb_load & (ex_wb_rd != '0) & (|match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stage controller: prioritised stall/flush decode, state tracking,
// data-memory wait timeout and saturating performance counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_wb_load,
  input  logic [REG_W-1:0] ex_wb_rd,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
);

  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic              load_use;
  logic              mem_stall;
  logic [1:0]        state_reg, state_next;
  stage_ctrl_t       ctrl;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_timeout_reg, mem_timeout_next;
  logic [PERF_N-1:0] perf_inc;
  logic [31:0]       perf_cnt [PERF_N];

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_wb_load  (ex_wb_load),
    .ex_wb_rd    (ex_wb_rd),
    .load_use    (load_use)
  );

  assign mem_stall = mem_access & ~mem_ready;

  // A redirect under a memory stall is simply deferred: EX is held, so the
  // redirect stays asserted until the stall releases and then wins.
  always_comb begin
    state_next = ST_RUN;
    if (mem_stall)        state_next = ST_MEM_WAIT;
    else if (ex_redirect) state_next = ST_REDIRECT;
    else if (load_use)    state_next = ST_LOAD_STALL;
  end

  assign ctrl = rst ? CTRL_CLEAR : stage_ctrl(state_next);

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_en     = ctrl.id_ex_en;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    wait_cnt_next = '0;
    if (mem_stall)
      wait_cnt_next = (&wait_cnt_reg) ? wait_cnt_reg : wait_cnt_reg + WAIT_W'(1);
  end

  // Sticky: only reset may clear it, perf_clr deliberately leaves it alone.
  assign mem_timeout_next = mem_timeout_reg |
                            (mem_stall & (wait_cnt_next >= WAIT_W'(TIMEOUT_CYCLES)));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  assign perf_inc[PERF_STALL] = ~ctrl.pc_en;
  assign perf_inc[PERF_FLUSH] = ctrl.if_id_flush;

  genvar gi;
  for (gi = 0; gi < PERF_N; gi++) begin : g_perf
    logic [31:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (rst || perf_clr)
        cnt_reg <= '0;
      else if (perf_inc[gi] && (cnt_reg != '1))
        cnt_reg <= cnt_reg + 32'd1;
    end

    assign perf_cnt[gi] = cnt_reg;
  end

  assign state        = state_reg;
  assign mem_timeout  = mem_timeout_reg;
  assign stall_cycles = perf_cnt[PERF_STALL];
  assign flush_events = perf_cnt[PERF_FLUSH];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for the priority decode plus
// hand-written multi-cycle sequences for stalls, deferred redirect and timeout.
module tb_pipeline_ctrl;

  localparam logic [1:0] S_RUN = 2'd0, S_LU = 2'd1, S_MW = 2'd2, S_RD = 2'd3;
  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush}
  localparam logic [8:0] C_RUN = 9'b110101010;
  localparam logic [8:0] C_LU  = 9'b000111010;
  localparam logic [8:0] C_MW  = 9'b000000011;
  localparam logic [8:0] C_RD  = 9'b111111010;
  localparam logic [8:0] C_RST = 9'b111111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_wb_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_wb_load, ex_redirect;
  logic        mem_access, mem_ready, perf_clr;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_events;
  logic [8:0]  ctrl;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_wb_load(ex_wb_load), .ex_wb_rd(ex_wb_rd), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .state(state), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush};

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, redir, macc, mrdy;
    logic [8:0] exp_ctrl;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs [13];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                              input logic u2, input logic ld, input logic [4:0] rd,
                              input logic redir, input logic macc, input logic mrdy,
                              input logic [8:0] ec, input logic [1:0] es);
    vec_t v;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.ld = ld; v.rd = rd;
    v.redir = redir; v.macc = macc; v.mrdy = mrdy; v.exp_ctrl = ec; v.exp_state = es;
    return v;
  endfunction

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_wb_load = 0; ex_wb_rd = 0; ex_redirect = 0;
    mem_access = 0; mem_ready = 1; perf_clr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; idle();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 0;
  endtask

  int exp_stall, exp_flush;

  initial begin
    rst = 1; idle();
    vecs[0]  = mk(5'd0,  0, 5'd0,  0, 0, 5'd0,  0, 0, 1, C_RUN, S_RUN);
    vecs[1]  = mk(5'd5,  1, 5'd0,  0, 1, 5'd5,  0, 0, 1, C_LU,  S_LU);
    vecs[2]  = mk(5'd0,  1, 5'd0,  0, 1, 5'd0,  0, 0, 1, C_RUN, S_RUN);
    vecs[3]  = mk(5'd3,  1, 5'd7,  1, 1, 5'd7,  0, 0, 1, C_LU,  S_LU);
    vecs[4]  = mk(5'd7,  0, 5'd2,  1, 1, 5'd7,  0, 0, 1, C_RUN, S_RUN);
    vecs[5]  = mk(5'd9,  1, 5'd0,  0, 0, 5'd9,  0, 0, 1, C_RUN, S_RUN);
    vecs[6]  = mk(5'd0,  0, 5'd0,  0, 0, 5'd0,  1, 0, 1, C_RD,  S_RD);
    vecs[7]  = mk(5'd5,  1, 5'd0,  0, 1, 5'd5,  1, 0, 1, C_RD,  S_RD);
    vecs[8]  = mk(5'd0,  0, 5'd0,  0, 0, 5'd0,  0, 1, 0, C_MW,  S_MW);
    vecs[9]  = mk(5'd0,  0, 5'd0,  0, 0, 5'd0,  0, 1, 1, C_RUN, S_RUN);
    vecs[10] = mk(5'd6,  1, 5'd0,  0, 1, 5'd6,  1, 1, 0, C_MW,  S_MW);
    vecs[11] = mk(5'd0,  0, 5'd0,  0, 0, 5'd0,  0, 0, 0, C_RUN, S_RUN);
    vecs[12] = mk(5'd1,  0, 5'd31, 1, 1, 5'd31, 0, 0, 1, C_LU,  S_LU);

    // Reset state and forced outputs.
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    check("rst_ctrl", 32'(ctrl), 32'(C_RST));
    check("rst_state", 32'(state), 32'(S_RUN));
    check("rst_stall", stall_cycles, 0);
    check("rst_flush", flush_events, 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    rst = 0;

    exp_stall = 0; exp_flush = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      id_rs1 = vecs[i].rs1; id_uses_rs1 = vecs[i].u1;
      id_rs2 = vecs[i].rs2; id_uses_rs2 = vecs[i].u2;
      ex_wb_load = vecs[i].ld; ex_wb_rd = vecs[i].rd; ex_redirect = vecs[i].redir;
      mem_access = vecs[i].macc; mem_ready = vecs[i].mrdy;
      #1;
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
      if (!vecs[i].exp_ctrl[8]) exp_stall++;
      if (vecs[i].exp_ctrl[6])  exp_flush++;
      @(posedge clk); #1;
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_stall", i), stall_cycles, 32'(exp_stall));
      check($sformatf("vec%0d_flush", i), flush_events, 32'(exp_flush));
      $display("vec %0d: ctrl=%b state=%0d stall=%0d flush=%0d", i, ctrl, state, stall_cycles, flush_events);
    end

    // Memory stall for three cycles, then ack.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); mem_access = 1; mem_ready = 0; #1;
      check($sformatf("mw%0d_ctrl", k), 32'(ctrl), 32'(C_MW));
      @(posedge clk); #1;
      check($sformatf("mw%0d_state", k), 32'(state), 32'(S_MW));
    end
    @(negedge clk); mem_ready = 1; #1;
    check("mw_release_ctrl", 32'(ctrl), 32'(C_RUN));
    @(posedge clk); #1;
    check("mw_release_state", 32'(state), 32'(S_RUN));
    check("mw_stall_cnt", stall_cycles, 3);
    check("mw_flush_cnt", flush_events, 0);
    $display("seq mem_wait: stall=%0d state=%0d", stall_cycles, state);

    // Single load-use: one LOAD_STALL then RUN; then redirect over load-use.
    do_reset();
    @(negedge clk); ex_wb_load = 1; ex_wb_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
    @(posedge clk); #1;
    check("lu_state", 32'(state), 32'(S_LU));
    @(negedge clk); idle();
    @(posedge clk); #1;
    check("lu_after_state", 32'(state), 32'(S_RUN));
    check("lu_stall_cnt", stall_cycles, 1);
    @(negedge clk); ex_wb_load = 1; ex_wb_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1; ex_redirect = 1; #1;
    check("rdlu_ctrl", 32'(ctrl), 32'(C_RD));
    @(posedge clk); #1;
    check("rdlu_flush_cnt", flush_events, 1);
    check("rdlu_stall_cnt", stall_cycles, 1);
    $display("seq load_use/redirect: stall=%0d flush=%0d", stall_cycles, flush_events);

    // Redirect deferred by a two-cycle memory stall.
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); ex_redirect = 1; mem_access = 1; mem_ready = 0; #1;
      check($sformatf("rdmw%0d_flushes", k), 32'({if_id_flush, id_ex_flush}), 0);
      @(posedge clk); #1;
      check($sformatf("rdmw%0d_flush_cnt", k), flush_events, 0);
    end
    @(negedge clk); mem_ready = 1; #1;
    check("rdmw3_ctrl", 32'(ctrl), 32'(C_RD));
    @(posedge clk); #1;
    check("rdmw3_flush_cnt", flush_events, 1);
    check("rdmw3_stall_cnt", stall_cycles, 2);
    check("rdmw3_state", 32'(state), 32'(S_RD));
    $display("seq deferred redirect: flush=%0d stall=%0d", flush_events, stall_cycles);

    // Timeout after the fourth wait edge; sticky across perf_clr.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); mem_access = 1; mem_ready = 0;
      @(posedge clk); #1;
      check($sformatf("to%0d_timeout", k), 32'(mem_timeout), (k >= 4) ? 1 : 0);
    end
    @(negedge clk); perf_clr = 1;
    @(posedge clk); #1;
    check("clr_stall_cnt", stall_cycles, 0);
    check("clr_flush_cnt", flush_events, 0);
    check("clr_timeout", 32'(mem_timeout), 1);
    @(negedge clk); idle();
    @(posedge clk); #1;
    check("post_clr_stall", stall_cycles, 0);
    check("post_clr_timeout", 32'(mem_timeout), 1);
    $display("seq timeout: timeout=%0d stall=%0d", mem_timeout, stall_cycles);

    // Reset mid-wait abandons it and clears the sticky error.
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); mem_access = 1; mem_ready = 0;
      @(posedge clk);
    end
    @(negedge clk); rst = 1; #1;
    check("midrst_ctrl", 32'(ctrl), 32'(C_RST));
    @(posedge clk); #1;
    check("midrst_state", 32'(state), 32'(S_RUN));
    check("midrst_timeout", 32'(mem_timeout), 0);
    check("midrst_stall", stall_cycles, 0);
    @(negedge clk); rst = 0; idle();
    @(posedge clk); #1;
    check("postrst_state", 32'(state), 32'(S_RUN));
    $display("seq mid-wait reset: state=%0d timeout=%0d", state, mem_timeout);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have inputs id_rs1, id_rs2 (5 each, ID source regs) and id_uses_rs1, id_uses_rs2 (1 each, source valid).
REQ-003 SHALL have inputs ex_wb_load (1, load in EX) and ex_wb_rd (5, EX destination).
REQ-004 SHALL have input ex_redirect (1, EX resolved mispredicted branch/jump).
REQ-005 SHALL have inputs mem_access (1, load/store in MEM), mem_ready (1, data memory ack) and perf_clr (1, counter clear).
REQ-006 SHALL have outputs pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush (1 each, stage-register controls).
REQ-007 SHALL have outputs state (2, FSM state), mem_timeout (1, sticky error), stall_cycles (32) and flush_events (32).
REQ-008 SHALL use parameter TIMEOUT_CYCLES, default 255, meaning the MEM_WAIT cycle count that sets mem_timeout.

Function
REQ-009 Stage controls SHALL be combinational from the current inputs, with priority mem-stall > redirect > load-use > run.
REQ-010 mem-stall (mem_access & !mem_ready): pc/if_id/id_ex/ex_mem en=0, mem_wb_en=1, mem_wb_flush=1, other flushes 0.
REQ-011 redirect (ex_redirect, no mem-stall): all en=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=0, mem_wb_flush=0.
REQ-012 load-use: ex_wb_load & ex_wb_rd!=0 & ((id_uses_rs1 & id_rs1==ex_wb_rd) | (id_uses_rs2 & id_rs2==ex_wb_rd)).
REQ-013 load-use without higher priority: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
REQ-014 run: all en=1, all flush=0.
REQ-015 Redirect SHALL override load-use in the same cycle; the stalled ID instruction is squashed.
REQ-016 Redirect during mem-stall SHALL NOT flush; it takes effect in the first cycle mem_ready is high, because EX is held.
REQ-017 FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2, REDIRECT=3; next state = condition selected in REQ-009 this cycle.
REQ-018 A single load-use hazard SHALL produce exactly one LOAD_STALL cycle, followed by RUN, or by MEM_WAIT if the load misses.
REQ-019 wait_cnt (8-bit min) SHALL clear outside MEM_WAIT, increment each MEM_WAIT cycle, and saturate.
REQ-020 mem_timeout SHALL set on the edge where wait_cnt reaches TIMEOUT_CYCLES and hold until rst.
REQ-021 stall_cycles SHALL increment on every edge with pc_en=0, saturating at 0xFFFFFFFF.
REQ-022 flush_events SHALL increment on every edge with if_id_flush=1, saturating.
REQ-023 perf_clr SHALL zero both counters on the next edge, overriding any increment in that cycle; it SHALL NOT clear mem_timeout.

Reset
REQ-024 On rst, state SHALL become RUN and wait_cnt, mem_timeout, stall_cycles and flush_events SHALL become 0.
REQ-025 While rst is high, outputs SHALL be forced: pc/all en=1, if_id_flush=id_ex_flush=ex_mem_flush=mem_wb_flush=1 (pipeline cleared).
REQ-026 rst asserted mid-MEM_WAIT SHALL abandon the wait; the cycle after deassertion SHALL be in RUN.

Structure
REQ-027 State encodings and the TIMEOUT_CYCLES default SHALL reside in the shared core package (pipeline_pkg).
REQ-028 The hazard compare SHALL be a sub-module hazard_detect (pure combinational, REQ-012); the FSM and counters stay in pipeline_ctrl.

Verification
REQ-029 ex_wb_load=1, ex_wb_rd=5, id_rs1=5, id_uses_rs1=1, one cycle -> pc_en=0, id_ex_flush=1, state=LOAD_STALL next, stall_cycles=1.
REQ-030 Same as REQ-029 but ex_wb_rd=0 -> run outputs, state stays RUN, stall_cycles=0.
REQ-031 mem_access=1, mem_ready=0 for 3 cycles then 1 -> en freeze 3 cycles, mem_wb_flush=1 each, stall_cycles=3, state MEM_WAIT then RUN.
REQ-032 ex_redirect=1 with a load-use condition -> if_id_flush=id_ex_flush=1, pc_en=1, flush_events=1, stall_cycles unchanged.
REQ-033 ex_redirect=1 with mem_ready=0 for 2 cycles -> no flushes for 2 cycles, flush on cycle 3, flush_events=1.
REQ-034 TIMEOUT_CYCLES=4, mem_ready=0 for 6 cycles -> mem_timeout rises after the 4th wait edge and stays 1; perf_clr leaves it set.
